// File: rtl/alu_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// alu_ctrl_sequencer
//   Multi-cycle control FSM between instruction fetch and the 64-bit ALU
//   datapath. Accepts one RV64 instruction per valid/ready handshake and
//   decodes it into a 4-bit ALU control code. It then steps through
//   EXEC/MEM/WB, samples the ALU Zero flag for beq, and pulses done when the
//   instruction retires. Only one instruction is in flight at a time.
//
// Parameters
//   EXEC_CYCLES  ALU settle cycles spent in EXEC (1..15)
//   MEM_TIMEOUT  MEM cycles allowed before a missing mem_ack is an error (1..255)
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   instr_valid   in   instr carries an instruction
//   instr_ready   out  sequencer is idle and can accept
//   instr[31:0]   in   RV64 instruction word
//   alu_control   out  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
//   alu_src_imm   out  ALU B operand is the immediate (ld/sd)
//   alu_zero      in   ALU Zero flag
//   mem_read      out  held during MEM for ld
//   mem_write     out  held during MEM for sd
//   mem_ack       in   memory completion, sampled during MEM
//   reg_write     out  one-cycle writeback strobe
//   branch_taken  out  valid with done: beq and Zero was set
//   done          out  one-cycle end-of-instruction pulse
//   error         out  valid with done: illegal opcode or MEM timeout
// ---------------------------------------------------------------------------
module alu_ctrl_sequencer #(
    parameter int EXEC_CYCLES = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  alu_control,
    output logic        alu_src_imm,
    input  logic        alu_zero,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ack,
    output logic        reg_write,
    output logic        branch_taken,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_FIN
    } state_t;

    typedef enum logic [2:0] {
        K_ILLEGAL, K_RTYPE, K_LD, K_SD, K_BEQ
    } kind_t;

    localparam logic [7:0] EXEC_LAST = 8'(EXEC_CYCLES);
    localparam logic [7:0] MEM_LAST  = 8'(MEM_TIMEOUT);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instr;
    logic [7:0]  r_cnt;     // cycles spent in the current EXEC/MEM visit, 1-based
    logic        r_ready;
    logic        r_zero;    // Zero flag captured on the last EXEC cycle of a beq
    logic        r_err;

    kind_t       w_kind;
    logic [3:0]  w_alu_code;
    logic        w_accept;
    logic        w_exec_last;
    logic        w_mem_last;
    logic        w_unused_fields;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;

    assign w_opcode = r_instr[6:0];
    assign w_funct3 = r_instr[14:12];
    assign w_funct7 = r_instr[31:25];

    // Register and immediate fields are consumed by the datapath, not here.
    assign w_unused_fields = ^{r_instr[24:15], r_instr[11:7]};

    // Ready is only ever set while IDLE, so it alone qualifies the handshake.
    assign w_accept    = r_ready && instr_valid;
    assign w_exec_last = (r_cnt == EXEC_LAST);
    assign w_mem_last  = (r_cnt == MEM_LAST);

    // Decode of the latched instruction.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can leave it unassigned (no latch).
        w_kind     = K_ILLEGAL;
        w_alu_code = ALU_AND;
        case (w_opcode)
            7'b0110011: begin
                if (w_funct3 == 3'b000 && w_funct7 == 7'b0000000) begin
                    w_kind = K_RTYPE; w_alu_code = ALU_ADD;
                end else if (w_funct3 == 3'b000 && w_funct7 == 7'b0100000) begin
                    w_kind = K_RTYPE; w_alu_code = ALU_SUB;
                end else if (w_funct3 == 3'b111 && w_funct7 == 7'b0000000) begin
                    w_kind = K_RTYPE; w_alu_code = ALU_AND;
                end else if (w_funct3 == 3'b110 && w_funct7 == 7'b0000000) begin
                    w_kind = K_RTYPE; w_alu_code = ALU_OR;
                end
            end
            7'b0000011: begin
                if (w_funct3 == 3'b011) begin
                    w_kind = K_LD; w_alu_code = ALU_ADD;
                end
            end
            7'b0100011: begin
                if (w_funct3 == 3'b011) begin
                    w_kind = K_SD; w_alu_code = ALU_ADD;
                end
            end
            7'b1100011: begin
                if (w_funct3 == 3'b000) begin
                    w_kind = K_BEQ; w_alu_code = ALU_SUB;
                end
            end
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_DECODE;
            S_DECODE: w_next = (w_kind == K_ILLEGAL) ? S_FIN : S_EXEC;
            S_EXEC: begin
                if (w_exec_last) begin
                    case (w_kind)
                        K_RTYPE:    w_next = S_WB;
                        K_LD, K_SD: w_next = S_MEM;
                        default:    w_next = S_FIN;
                    endcase
                end
            end
            S_MEM: begin
                // An ack on the final allowed cycle still counts as success.
                if (mem_ack)         w_next = (w_kind == K_LD) ? S_WB : S_FIN;
                else if (w_mem_last) w_next = S_FIN;
            end
            S_WB:     w_next = S_IDLE;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_zero  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples values from before this edge, independent of order.
            r_state <= w_next;
            // Registered ready stays low through reset and rises the cycle the
            // FSM actually sits in IDLE.
            r_ready <= (w_next == S_IDLE);

            if (w_accept) begin
                r_instr <= instr;
                r_zero  <= 1'b0;
                r_err   <= 1'b0;
            end

            if (r_state == S_DECODE && w_kind == K_ILLEGAL) begin
                r_err <= 1'b1;
            end
            if (r_state == S_MEM && !mem_ack && w_mem_last) begin
                r_err <= 1'b1;
            end
            if (r_state == S_EXEC && w_exec_last && w_kind == K_BEQ) begin
                r_zero <= alu_zero;
            end

            if (w_next != r_state) begin
                r_cnt <= (w_next == S_EXEC || w_next == S_MEM) ? 8'd1 : 8'd0;
            end else if (r_state == S_EXEC || r_state == S_MEM) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Outputs depend only on registered state and the latched instruction.
    always_comb begin
        instr_ready  = r_ready;
        alu_control  = ALU_AND;
        alu_src_imm  = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        branch_taken = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        case (r_state)
            S_EXEC, S_MEM: begin
                alu_control = w_alu_code;
                alu_src_imm = (w_kind == K_LD) || (w_kind == K_SD);
                mem_read    = (r_state == S_MEM) && (w_kind == K_LD);
                mem_write   = (r_state == S_MEM) && (w_kind == K_SD);
            end
            S_WB: begin
                reg_write = 1'b1;
                done      = 1'b1;
            end
            S_FIN: begin
                done         = 1'b1;
                branch_taken = (w_kind == K_BEQ) && r_zero;
                error        = r_err;
            end
            default: ;
        endcase
    end

endmodule
